msb_serializer: RTL and testbench

Parallel-to-serial front end for the serial modulo-3 detector. Accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first, one bit per clock, on a bit line that drives the detector's `x` input. Before each word it issues a one-cycle clear pulse so the detector starts every word from remainder 0. It also provides framing strobes (first/last bit) and, optionally, a golden remainder for self-checking.

---
 rtl/msb_serializer_pkg.sv | 43 ++++
 rtl/msb_serializer_mod3_ref_tracker.sv | 45 ++++
 rtl/msb_serializer.sv | 157 +++++++++++++++
 tb/tb_msb_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msb_serializer_pkg.sv
// msb_serializer_pkg: shared types and helpers for the MSB-first serializer.
// Holds the FSM state encoding, the modulo-3 remainder step used by the
// optional reference tracker, and parameter legality checks.
package msb_serializer_pkg;

  // Serializer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Width of the inter-word gap counter (GAP is at most 15).
  localparam int GAP_CNT_W = 4;

  // One step of the serial mod-3 recurrence: r' = (2r + b) mod 3.
  // An out-of-range remainder (3) folds back to 0.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] nxt;
    case ({r, b})
      3'b00_0: nxt = 2'd0;
      3'b00_1: nxt = 2'd1;
      3'b01_0: nxt = 2'd2;
      3'b01_1: nxt = 2'd0;
      3'b10_0: nxt = 2'd1;
      3'b10_1: nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Word width must be 2..32.
  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

  // Gap length must be 0..15.
  function automatic bit gap_ok(input int g);
    return (g >= 0) && (g <= 15);
  endfunction

endpackage

// File: rtl/msb_serializer_mod3_ref_tracker.sv
// mod3_ref_tracker: golden remainder of the bit stream leaving the
// serializer. Cleared by the serializer's clr pulse, advanced on every
// payload bit, and flags the final remainder one cycle after the last bit.
module mod3_ref_tracker
  import msb_serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  input  logic       last,
  output logic [1:0] rem,
  output logic       rem_valid
);

  logic [1:0] rem_q, rem_d;
  logic       valid_q, valid_d;

  // Next remainder: clear wins, otherwise step on each payload bit.
  always_comb begin
    rem_d   = rem_q;
    valid_d = last;
    if (clr) begin
      rem_d = 2'd0;
    end else if (en) begin
      rem_d = mod3_step(rem_q, bit_in);
    end
  end

  // Remainder and valid-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign rem       = rem_q;
  assign rem_valid = valid_q;

endmodule

// File: rtl/msb_serializer.sv
// msb_serializer: accepts a WIDTH-bit word on a valid/ready handshake and
// emits it MSB-first, one bit per clock, preceded by a one-cycle clr pulse
// for the downstream mod-3 detector. Optional golden remainder outputs are
// compiled in with the macro MSB_SERIALIZER_REF_MOD3_EN.
module msb_serializer
  import msb_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             clr,
  output logic             busy
`ifdef MSB_SERIALIZER_REF_MOD3_EN
  ,
  output logic [1:0]       ref_rem,
  output logic             ref_valid
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;
  localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

  // Reject illegal configurations at elaboration.
  if (!(width_ok(WIDTH) && gap_ok(GAP))) begin : g_bad_cfg
    $error("msb_serializer: WIDTH must be 2..32 and GAP 0..15");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic in_ready_q, in_ready_d;
  logic busy_q, busy_d;
  logic clr_q, clr_d;
  logic x_q, x_d;
  logic x_valid_q, x_valid_d;
  logic sof_q, sof_d;
  logic eof_q, eof_d;

  // Next-state logic: load on handshake, shift while serializing, count gap.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CLEAR;
          shift_d = in_data;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    clr_d      = (state_d == ST_CLEAR);
    x_valid_d  = (state_d == ST_SHIFT);
    x_d        = x_valid_d & shift_d[WIDTH-1];
    sof_d      = (state_q == ST_CLEAR);
    eof_d      = x_valid_d && (cnt_d == '0);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      x_q        <= 1'b0;
      x_valid_q  <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      clr_q      <= clr_d;
      x_q        <= x_d;
      x_valid_q  <= x_valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign clr      = clr_q;
  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign sof      = sof_q;
  assign eof      = eof_q;

`ifdef MSB_SERIALIZER_REF_MOD3_EN
  mod3_ref_tracker u_ref (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_q),
    .en        (x_valid_q),
    .bit_in    (x_q),
    .last      (eof_q),
    .rem       (ref_rem),
    .rem_valid (ref_valid)
  );
`endif

endmodule

// File: tb/tb_msb_serializer.sv
// Bench for msb_serializer: three instances (W8/GAP0, W8/GAP3, W2/GAP0)
// share one stimulus stream. A timeline model (cycles since handshake)
// predicts every output each cycle; directed checks pin framing and data.
module tb_msb_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  logic rdy_a, busy_a, clr_a, x_a, xv_a, sof_a, eof_a;
  logic rdy_b, busy_b, clr_b, x_b, xv_b, sof_b, eof_b;
  logic rdy_c, busy_c, clr_c, x_c, xv_c, sof_c, eof_c;
`ifdef MSB_SERIALIZER_REF_MOD3_EN
  logic [1:0] rr_a, rr_b, rr_c;
  logic       rv_a, rv_b, rv_c;
`endif

  msb_serializer #(.WIDTH(8), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(in_valid), .in_ready(rdy_a),
    .x(x_a), .x_valid(xv_a), .sof(sof_a), .eof(eof_a), .clr(clr_a), .busy(busy_a)
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    , .ref_rem(rr_a), .ref_valid(rv_a)
`endif
  );

  msb_serializer #(.WIDTH(8), .GAP(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(in_valid), .in_ready(rdy_b),
    .x(x_b), .x_valid(xv_b), .sof(sof_b), .eof(eof_b), .clr(clr_b), .busy(busy_b)
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    , .ref_rem(rr_b), .ref_valid(rv_b)
`endif
  );

  msb_serializer #(.WIDTH(2), .GAP(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(din[1:0]), .in_valid(in_valid), .in_ready(rdy_c),
    .x(x_c), .x_valid(xv_c), .sof(sof_c), .eof(eof_c), .clr(clr_c), .busy(busy_c)
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    , .ref_rem(rr_c), .ref_valid(rv_c)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {in_ready, busy, clr, x_valid, x, sof, eof} at t cycles after
  // the accepting edge (t=0 means idle).
  function automatic logic [6:0] exp_vec(input int t, input logic [7:0] w,
                                         input int wd, input int g);
    logic bz, xv, xb;
    bz = (t >= 1) && (t <= wd + 1 + g);
    xv = (t >= 2) && (t <= wd + 1);
    xb = 1'b0;
    if (xv) xb = w[wd + 1 - t];
    return {!bz, bz, t == 1, xv, xb, t == 2, t == wd + 1};
  endfunction

  int         wd_m [3] = '{8, 8, 2};
  int         gp_m [3] = '{0, 3, 0};
  int         t_m  [3] = '{0, 0, 0};
  logic [7:0] w_m  [3] = '{8'h00, 8'h00, 8'h00};
  logic [6:0] act  [3];
`ifdef MSB_SERIALIZER_REF_MOD3_EN
  logic       prev_eof_m [3] = '{1'b0, 1'b0, 1'b0};
  int         last_rem_m [3] = '{0, 0, 0};
  logic [1:0] act_rem [3];
  logic       act_rv  [3];
`endif

  // Observed stream bookkeeping.
  int         cyc = 0;
  logic [7:0] cap_a = 8'h00, last_a = 8'h00;
  logic [1:0] cap_c = 2'b00, last_c = 2'b00;
  int eof_cnt_a = 0, sof_cyc_a = 0, eof_cyc_a = 0, clr_cyc_a = 0, clr_gap_a = 0;
  int clr_cyc_b = 0, clr_gap_b = 0, sof_cyc_c = 0, eof_cyc_c = 0;

  // Per-cycle compare against the model, stream capture, model advance.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      act[0] = {rdy_a, busy_a, clr_a, xv_a, x_a, sof_a, eof_a};
      act[1] = {rdy_b, busy_b, clr_b, xv_b, x_b, sof_b, eof_b};
      act[2] = {rdy_c, busy_c, clr_c, xv_c, x_c, sof_c, eof_c};
`ifdef MSB_SERIALIZER_REF_MOD3_EN
      act_rem[0] = rr_a; act_rem[1] = rr_b; act_rem[2] = rr_c;
      act_rv[0]  = rv_a; act_rv[1]  = rv_b; act_rv[2]  = rv_c;
`endif
      for (int i = 0; i < 3; i++) begin
        logic [6:0] e;
        e = rst ? exp_vec(t_m[i], w_m[i], wd_m[i], gp_m[i]) : 7'b1000000;
        check($sformatf("dut%0d_outputs_cyc%0d", i, cyc), {25'b0, act[i]}, {25'b0, e});
`ifdef MSB_SERIALIZER_REF_MOD3_EN
        check($sformatf("dut%0d_ref_valid_cyc%0d", i, cyc), {31'b0, act_rv[i]},
              {31'b0, rst ? prev_eof_m[i] : 1'b0});
        if (!rst || t_m[i] <= 1 || t_m[i] > wd_m[i] + 1)
          check($sformatf("dut%0d_ref_rem_cyc%0d", i, cyc), {30'b0, act_rem[i]},
                rst ? last_rem_m[i] : 0);
`endif
      end

      if (xv_a) cap_a = {cap_a[6:0], x_a};
      if (sof_a) sof_cyc_a = cyc;
      if (eof_a) begin last_a = cap_a; eof_cnt_a++; eof_cyc_a = cyc; end
      if (clr_a) begin clr_gap_a = cyc - clr_cyc_a; clr_cyc_a = cyc; end
      if (clr_b) begin clr_gap_b = cyc - clr_cyc_b; clr_cyc_b = cyc; end
      if (xv_c) cap_c = {cap_c[0], x_c};
      if (sof_c) sof_cyc_c = cyc;
      if (eof_c) begin last_c = cap_c; eof_cyc_c = cyc; end

      for (int i = 0; i < 3; i++) begin
`ifdef MSB_SERIALIZER_REF_MOD3_EN
        prev_eof_m[i] = rst && (t_m[i] == wd_m[i] + 1);
        if (!rst) last_rem_m[i] = 0;
        else if (t_m[i] == wd_m[i] + 1) last_rem_m[i] = int'(w_m[i]) % 3;
`endif
        if (!rst) begin
          t_m[i] = 0;
        end else if (t_m[i] == 0) begin
          if (in_valid) begin
            t_m[i] = 1;
            w_m[i] = (wd_m[i] == 8) ? din : {6'b0, din[1:0]};
          end
        end else if (t_m[i] == wd_m[i] + 1 + gp_m[i]) begin
          t_m[i] = 0;
        end else begin
          t_m[i] = t_m[i] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one word for one handshake edge once dut_a is ready.
  task automatic send(input logic [7:0] w);
    int n = 0;
    while (!rdy_a && n < 60) begin
      tick();
      n++;
    end
    if (!rdy_a) check("send_ready_timeout", {31'b0, rdy_a}, 1);
    in_valid = 1'b1;
    din      = w;
    tick();
    in_valid = 1'b0;
  endtask

  int eof_before;

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("reset_a", {25'b0, rdy_a, busy_a, clr_a, xv_a, x_a, sof_a, eof_a}, 32'h40);
    check("reset_b", {25'b0, rdy_b, busy_b, clr_b, xv_b, x_b, sof_b, eof_b}, 32'h40);
    check("reset_c", {25'b0, rdy_c, busy_c, clr_c, xv_c, x_c, sof_c, eof_c}, 32'h40);
    rst = 1'b1;
    tick();

    // Single words with known remainders.
    send(8'hB7); repeat (12) tick();
    check("b7_stream", {24'b0, last_a}, 32'hB7);
    check("b7_sof_after_clr", sof_cyc_a - clr_cyc_a, 1);
    check("b7_eof_after_sof", eof_cyc_a - sof_cyc_a, 7);
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    check("b7_rem", {30'b0, rr_a}, 0);
`endif
    send(8'h0A); repeat (12) tick();
    check("0a_stream", {24'b0, last_a}, 32'h0A);
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    check("0a_rem", {30'b0, rr_a}, 1);
`endif
    send(8'h80); repeat (12) tick();
    check("80_stream", {24'b0, last_a}, 32'h80);
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    check("80_rem", {30'b0, rr_a}, 2);
`endif
    send(8'hFF); repeat (12) tick();
    check("ff_stream", {24'b0, last_a}, 32'hFF);
    check("w2_stream", {30'b0, last_c}, 32'h3);
    check("w2_eof_after_sof", eof_cyc_c - sof_cyc_c, 1);
`ifdef MSB_SERIALIZER_REF_MOD3_EN
    check("ff_rem", {30'b0, rr_a}, 0);
    check("w2_rem", {30'b0, rr_c}, 0);
`endif

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    repeat (45) begin
      tick();
      din = 8'($urandom);
    end
    in_valid = 1'b0;
    check("b2b_clr_spacing_gap0", clr_gap_a, 10);
    check("b2b_clr_spacing_gap3", clr_gap_b, 13);
    repeat (15) tick();

    // Reset during the 4th bit of 8'hB7.
    eof_before = eof_cnt_a;
    send(8'hB7);
    repeat (4) tick();
    check("midrst_bit4_x", {31'b0, x_a}, 1);
    check("midrst_bit4_valid", {31'b0, xv_a}, 1);
    rst = 1'b0;
    #1;
    check("midrst_async_outputs", {25'b0, rdy_a, busy_a, clr_a, xv_a, x_a, sof_a, eof_a}, 32'h40);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_no_eof", eof_cnt_a, eof_before);
    send(8'h3C); repeat (12) tick();
    check("post_rst_stream", {24'b0, last_a}, 32'h3C);

    // in_valid pulsed and in_data changed while busy.
    send(8'h5C);
    tick();
    din = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; din = 8'hFF;
    repeat (12) tick();
    check("busy_ignore_stream", {24'b0, last_a}, 32'h5C);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din      = 8'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
